nono_image_binarizer: RTL and testbench

Upstream feeder of `constraint_generator`. It captures one 320x240 grayscale camera frame and thresholds each pixel to ink/blank. It majority-votes every 8x8 pixel block into one cell of a 40x30 puzzle bitmap. It then bursts the 30 bitmap rows out with exactly the timing `constraint_generator` expects: a start pulse with row 0, then rows 1..29 on consecutive cycles.

---
 rtl/nono_image_binarizer.sv | 132 +++++++++++++
 tb/tb_nono_image_binarizer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nono_image_binarizer.sv
// Captures a 320x240 grayscale frame and majority-votes each 8x8 block into a 40x30 bitmap.
// The bitmap is then burst out one row per cycle. Define NONO_INVERT_EN to treat bright pixels as ink.
module nono_image_binarizer #(
    parameter logic [7:0] THRESHOLD = 8'd128,
    parameter logic [6:0] MAJORITY  = 7'd32
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        capture_in,
    input  logic        frame_start_in,
    input  logic        pixel_valid_in,
    input  logic [7:0]  pixel_in,
    output logic        start_out,
    output logic [39:0] image_out,
    output logic        done_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACCUM = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [4:0]  k;
    logic [6:0]  cnt [40];
    logic [39:0] rows [30];

    logic        first;
    logic        accept;
    logic        ink;
    logic        commit;
    logic        last_pix;
    logic [8:0]  px;
    logic [7:0]  py;
    logic [5:0]  col;
    logic [6:0]  cnt_next [40];
    logic [39:0] commit_row;

    // Pixel qualification, effective coordinates and per-column count update.
    always_comb begin
        first    = pixel_valid_in && frame_start_in && ((state == ARMED) || (state == ACCUM));
        accept   = pixel_valid_in && ((state == ACCUM) || first);
        px       = first ? 9'd0 : x;
        py       = first ? 8'd0 : y;
        col      = px[8:3];
`ifdef NONO_INVERT_EN
        ink      = (pixel_in >= THRESHOLD);
`else
        ink      = (pixel_in < THRESHOLD);
`endif
        commit   = accept && (px == 9'd319) && (py[2:0] == 3'd7);
        last_pix = accept && (px == 9'd319) && (py == 8'd239);
        commit_row = 40'd0;
        for (int j = 0; j < 40; j++) begin
            cnt_next[j] = first ? 7'd0 : cnt[j];
            if (ink && (col == j[5:0]) && (cnt_next[j] != 7'd64)) begin
                cnt_next[j] = cnt_next[j] + 7'd1;
            end else begin
                cnt_next[j] = cnt_next[j];
            end
            commit_row[j] = (cnt_next[j] >= MAJORITY);
        end
    end

    // Next-state selection; the EMIT phase k=30 is the done/teardown cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = capture_in ? ARMED : IDLE;
            ARMED:   state_next = first ? ACCUM : ARMED;
            ACCUM:   state_next = last_pix ? EMIT : ACCUM;
            EMIT:    state_next = (k == 5'd30) ? IDLE : EMIT;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame datapath: raster position, block counters, row buffer and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            x         <= 9'd0;
            y         <= 8'd0;
            k         <= 5'd0;
            cnt       <= '{default: 7'd0};
            rows      <= '{default: 40'd0};
            start_out <= 1'b0;
            image_out <= 40'd0;
            done_out  <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            if (accept) begin
                if (px == 9'd319) begin
                    x <= 9'd0;
                    y <= (py == 8'd239) ? 8'd0 : py + 8'd1;
                end else begin
                    x <= px + 9'd1;
                    y <= py;
                end
                if (commit) begin
                    cnt           <= '{default: 7'd0};
                    rows[py[7:3]] <= commit_row;
                end else begin
                    cnt <= cnt_next;
                end
            end
            if ((state == EMIT) && (k != 5'd30)) begin
                k         <= k + 5'd1;
                image_out <= rows[k];
            end else begin
                k <= 5'd0;
            end
            start_out <= (state == EMIT) && (k == 5'd0);
            done_out  <= (state == EMIT) && (k == 5'd30);
            busy_out  <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_nono_image_binarizer.sv
// Scoreboard bench for nono_image_binarizer: a driver pushes expected rows, a monitor checks the burst.
module tb_nono_image_binarizer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        capture_in;
    logic        frame_start_in;
    logic        pixel_valid_in;
    logic [7:0]  pixel_in;
    logic        start_out;
    logic [39:0] image_out;
    logic        done_out;
    logic        busy_out;

    nono_image_binarizer dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .capture_in     (capture_in),
        .frame_start_in (frame_start_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_in       (pixel_in),
        .start_out      (start_out),
        .image_out      (image_out),
        .done_out       (done_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int          tests = 0;
    int          fails = 0;
    logic [39:0] exp_q [$];
    logic [39:0] exp_rows [30];
    int          exp_start_cyc = -1;
    int          start_cnt = 0;
    int          done_cnt = 0;
    bit          active = 1'b0;
    bit          done_due = 1'b0;
    int          k_mon = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Test image: block rows with distinct hand-chosen content.
    function automatic logic [7:0] pix(input int x, input int y);
        int br;
        int bc;
        int i;
        br = y / 8;
        bc = x / 8;
        i  = (y % 8) * 8 + (x % 8);
        if (br == 1) return 8'd0;
        if (br == 2) begin
            if (bc == 5) return (i < 32) ? 8'd0 : 8'd255;
            if (bc == 7) return (i < 31) ? 8'd0 : 8'd255;
            return 8'd255;
        end
        if (br == 4) return 8'd127;
        if (br == 5) return 8'd128;
        if (br >= 10 && br <= 13) return (((br + bc) % 2) == 0) ? 8'd0 : 8'd255;
        if (br == 29) return (bc == 39) ? 8'd0 : 8'd255;
        return 8'd255;
    endfunction

    task automatic init_expected();
`ifdef NONO_INVERT_EN
        for (int r = 0; r < 30; r++) exp_rows[r] = 40'hFF_FFFF_FFFF;
        exp_rows[1]  = 40'h00_0000_0000;
        exp_rows[4]  = 40'h00_0000_0000;
        exp_rows[10] = 40'hAA_AAAA_AAAA;
        exp_rows[11] = 40'h55_5555_5555;
        exp_rows[12] = 40'hAA_AAAA_AAAA;
        exp_rows[13] = 40'h55_5555_5555;
        exp_rows[29] = 40'h7F_FFFF_FFFF;
`else
        for (int r = 0; r < 30; r++) exp_rows[r] = 40'h00_0000_0000;
        exp_rows[1]  = 40'hFF_FFFF_FFFF;
        exp_rows[2]  = 40'h00_0000_0020;
        exp_rows[4]  = 40'hFF_FFFF_FFFF;
        exp_rows[10] = 40'h55_5555_5555;
        exp_rows[11] = 40'hAA_AAAA_AAAA;
        exp_rows[12] = 40'h55_5555_5555;
        exp_rows[13] = 40'hAA_AAAA_AAAA;
        exp_rows[29] = 40'h80_0000_0000;
`endif
    endtask

    // Monitor: checks start timing, each burst row against the queue, then the done pulse.
    always @(negedge clk_in) begin
        if (start_out === 1'b1) begin
            start_cnt++;
            check("start_time", 64'(cyc), 64'(exp_start_cyc));
            if (!active) begin
                active = 1'b1;
                k_mon  = 0;
            end
        end
        if (done_out === 1'b1) done_cnt++;
        if (active) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL burst_row: got row %0h with no expected row queued", image_out);
                active = 1'b0;
            end else begin
                check($sformatf("row%0d", k_mon), 64'(image_out), 64'(exp_q.pop_front()));
                check("start_only_k0", 64'(start_out), 64'(k_mon == 0));
                check("busy_in_emit", 64'(busy_out), 64'd1);
                k_mon++;
                if (k_mon == 30) begin
                    active   = 1'b0;
                    done_due = 1'b1;
                end
            end
        end else if (done_due) begin
            check("done_pulse", 64'(done_out), 64'd1);
            check("busy_fall", 64'(busy_out), 64'd0);
            done_due = 1'b0;
        end else if (done_out === 1'b1) begin
            check("spurious_done", 64'(done_out), 64'd0);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit gap_fs_done;
        init_expected();
        reset_in       = 1'b1;
        capture_in     = 1'b0;
        frame_start_in = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_in       = 8'd0;
        repeat (3) tick();
        reset_in = 1'b0;
        check("rst_start", 64'(start_out), 64'd0);
        check("rst_image", 64'(image_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);

        // Pixels and a frame start while idle must be ignored.
        frame_start_in = 1'b1;
        pixel_valid_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        repeat (20) tick();
        pixel_valid_in = 1'b0;
        tick();
        check("idle_busy", 64'(busy_out), 64'd0);

        capture_in = 1'b1;
        tick();
        capture_in = 1'b0;
        check("busy_rise", 64'(busy_out), 64'd1);

        // ARMED: pixels without frame start, and frame start without valid, are ignored.
        pixel_valid_in = 1'b1;
        repeat (50) tick();
        pixel_valid_in = 1'b0;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;

        // Aborted first frame of dark pixels, restarted at pixel 1000.
        for (int i = 0; i < 1000; i++) begin
            frame_start_in = (i == 0);
            capture_in     = (i == 500);
            pixel_valid_in = 1'b1;
            pixel_in       = 8'd0;
            tick();
        end
        capture_in = 1'b0;

        gap_fs_done = 1'b0;
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x < 320; x++) begin
                if (y >= 80 && y < 88 && $urandom_range(0, 1) == 1) begin
                    pixel_valid_in = 1'b0;
                    frame_start_in = !gap_fs_done;
                    gap_fs_done    = 1'b1;
                    pixel_in       = 8'd0;
                    tick();
                end
                frame_start_in = (x == 0 && y == 0);
                pixel_valid_in = 1'b1;
                pixel_in       = pix(x, y);
                if (x == 319 && y == 239) begin
                    exp_start_cyc = cyc + 2;
                    for (int r = 0; r < 30; r++) exp_q.push_back(exp_rows[r]);
                end
                tick();
            end
        end
        frame_start_in = 1'b0;
        pixel_valid_in = 1'b1;
        pixel_in       = 8'd0;

        // Capture and pixels during EMIT are ignored.
        repeat (5) tick();
        capture_in = 1'b1;
        tick();
        capture_in     = 1'b0;
        pixel_valid_in = 1'b0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) tick();
        check("done_seen", 64'(done_cnt), 64'd1);
        repeat (3) tick();
        check("no_rearm", 64'(busy_out), 64'd0);
        check("hold_row29", 64'(image_out), 64'(exp_rows[29]));

        // Reset in the middle of accumulation.
        capture_in = 1'b1;
        tick();
        capture_in = 1'b0;
        for (int i = 0; i < 400; i++) begin
            frame_start_in = (i == 0);
            pixel_valid_in = 1'b1;
            pixel_in       = 8'd0;
            tick();
        end
        frame_start_in = 1'b0;
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("mid_rst_busy", 64'(busy_out), 64'd0);
        check("mid_rst_image", 64'(image_out), 64'd0);
        check("mid_rst_start", 64'(start_out), 64'd0);
        check("mid_rst_done", 64'(done_out), 64'd0);
        repeat (100) tick();
        pixel_valid_in = 1'b0;
        repeat (40) tick();
        check("post_rst_busy", 64'(busy_out), 64'd0);
        check("start_count", 64'(start_cnt), 64'd1);
        check("done_count", 64'(done_cnt), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
